// File: rtl/sr_drv_pkg.sv
// Shared types and defaults for the gated-SR latch driver.
// Build option: define SR_READBACK_EN to enable latch readback checking.
package sr_drv_pkg;

   // Write-sequence states, 3-bit encoding
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETUP   = 3'd1,
      ST_PULSE   = 3'd2,
      ST_HOLD    = 3'd3,
      ST_RECOVER = 3'd4
   } state_t;

   // Default timer width; must hold max(PULSE_LEN, RECOVER_LEN)
   localparam int CNT_W_DEF = 4;

   // Timer reload value for a phase of len cycles (a length of 0 loads 0)
   function automatic int phase_load(input int len);
      return (len > 0) ? len - 1 : 0;
   endfunction

endpackage

// File: rtl/sr_drv_timer.sv
// Loadable down-counter shared by the PULSE and RECOVER phases.
// done is high while the count is zero; the count holds at zero.
module sr_drv_timer
   import sr_drv_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] value,
   output logic             done
);

   logic [CNT_W-1:0] cnt;

   // Load takes priority; otherwise count down to zero and stop
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= value;
      end else if (cnt != '0) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/sr_latch_driver.sv
// Sequencer driving set/reset/gate of a gated SR latch from a valid/ready
// write-request stream. Each write: SETUP, PULSE (gate high), HOLD, RECOVER.
// Build option: SR_READBACK_EN adds the q_fb input and a sticky err flag;
// without it err is tied low.
module sr_latch_driver
   import sr_drv_pkg::*;
#(
   parameter int PULSE_LEN   = 2,
   parameter int RECOVER_LEN = 1,
   parameter int CNT_W       = CNT_W_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req_valid,
   input  logic req_data,
   input  logic req_force,
`ifdef SR_READBACK_EN
   input  logic q_fb,
`endif
   output logic req_ready,
   output logic s,
   output logic r,
   output logic gate,
   output logic busy,
   output logic err
);

   localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(phase_load(PULSE_LEN));
   localparam logic [CNT_W-1:0] REC_LOAD   = CNT_W'(phase_load(RECOVER_LEN));

   state_t           state;
   logic             cmd;
   logic             shadow;
   logic             shadow_vld;
   logic             tmr_load;
   logic [CNT_W-1:0] tmr_val;
   logic             tmr_done;
   logic             skip;

   // Timer is reloaded on the single-cycle phases preceding each timed phase
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = '0;
      case (state)
         ST_SETUP: begin
            tmr_load = 1'b1;
            tmr_val  = PULSE_LOAD;
         end
         ST_HOLD: begin
            tmr_load = 1'b1;
            tmr_val  = REC_LOAD;
         end
         default: ;
      endcase
   end

   sr_drv_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (tmr_load),
      .value (tmr_val),
      .done  (tmr_done)
   );

   // A request matching the known latch contents needs no pulse
   assign skip = shadow_vld && (req_data == shadow) && !req_force;

`ifdef SR_READBACK_EN
   logic err_q;

   // Sticky readback mismatch, sampled at the end of HOLD
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (state == ST_HOLD && q_fb != cmd) begin
         err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   // Write-sequence FSM; outputs are registered alongside the next state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         cmd        <= 1'b0;
         shadow     <= 1'b0;
         shadow_vld <= 1'b0;
         s          <= 1'b0;
         r          <= 1'b0;
         gate       <= 1'b0;
         busy       <= 1'b0;
         req_ready  <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid && !skip) begin
                  cmd       <= req_data;
                  state     <= ST_SETUP;
                  s         <= req_data;
                  r         <= ~req_data;
                  gate      <= 1'b0;
                  busy      <= 1'b1;
                  req_ready <= 1'b0;
               end
            end
            ST_SETUP: begin
               state <= ST_PULSE;
               gate  <= 1'b1;
            end
            ST_PULSE: begin
               if (tmr_done) begin
                  state <= ST_HOLD;
                  gate  <= 1'b0;
               end
            end
            ST_HOLD: begin
               shadow     <= cmd;
               shadow_vld <= 1'b1;
`ifdef SR_READBACK_EN
               // A failed readback leaves the latch contents unknown
               if (q_fb != cmd) begin
                  shadow_vld <= 1'b0;
               end
`endif
               s <= 1'b0;
               r <= 1'b0;
               if (RECOVER_LEN == 0) begin
                  state     <= ST_IDLE;
                  busy      <= 1'b0;
                  req_ready <= 1'b1;
               end else begin
                  state <= ST_RECOVER;
               end
            end
            ST_RECOVER: begin
               if (tmr_done) begin
                  state     <= ST_IDLE;
                  busy      <= 1'b0;
                  req_ready <= 1'b1;
               end
            end
            default: begin
               state     <= ST_IDLE;
               s         <= 1'b0;
               r         <= 1'b0;
               gate      <= 1'b0;
               busy      <= 1'b0;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
